// File: rtl/multi_driver_if.sv
// multi_driver_if: upstream request/response bus of the multi-cycle unit driver.
//   master : request fabric side (drives req_valid/req_data/rsp_ready)
//   slave  : driver side (drives req_ready and the response payload)
// Optional macro MULTI_DRIVER_LATENCY_EN adds rsp_latency (CNT_W bits).
interface multi_driver_if #(
    parameter int unsigned WIDTH = 32
`ifdef MULTI_DRIVER_LATENCY_EN
    , parameter int unsigned CNT_W = 4
`endif
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_timeout;
`ifdef MULTI_DRIVER_LATENCY_EN
    logic [CNT_W-1:0] rsp_latency;
`endif

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout
`ifdef MULTI_DRIVER_LATENCY_EN
        , input rsp_latency
`endif
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_timeout
`ifdef MULTI_DRIVER_LATENCY_EN
        , output rsp_latency
`endif
    );
endinterface

// File: rtl/multi_driver.sv
// multi_driver: initiator-side sequencer for a start/done/out multi-cycle unit.
// Takes a request, pulses start with the operand, waits for done (bounded by
// TIMEOUT cycles), and returns the captured result on the response channel.
// Ports:
//   clock, reset (async active-low)
//   bus    : multi_driver_if.slave (req_valid/ready/data, rsp_valid/ready/data/timeout)
//   start  : one-cycle start pulse to the unit
//   inp    : operand to the unit, stable until the response is accepted
//   done   : unit result strobe, only honoured while waiting
//   out    : unit result
//   busy   : high whenever the driver is not idle
// Optional macro MULTI_DRIVER_LATENCY_EN: bus.rsp_latency reports the measured
// wait cycles (TIMEOUT on timeout).
// The unit itself expects an active-high synchronous reset driven with !reset.
module multi_driver #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    multi_driver_if.slave    bus,
    output logic             start,
    output logic [WIDTH-1:0] inp,
    input  logic             done,
    input  logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] inp_q, inp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             to_q, to_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
`ifdef MULTI_DRIVER_LATENCY_EN
    logic [CNT_W-1:0] lat_q, lat_d;
`endif

    // Next-state, datapath and state-decoded outputs (registered one cycle early).
    always_comb begin
        state_d = state_q;
        inp_d   = inp_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        to_d    = to_q;
`ifdef MULTI_DRIVER_LATENCY_EN
        lat_d   = lat_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    inp_d   = bus.req_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over an expiring counter on the same cycle
                if (done) begin
                    data_d  = out;
                    to_d    = 1'b0;
`ifdef MULTI_DRIVER_LATENCY_EN
                    lat_d   = cnt_q;
`endif
                    state_d = HOLD;
                end else if (cnt_q == TO_CNT) begin
                    data_d  = '0;
                    to_d    = 1'b1;
`ifdef MULTI_DRIVER_LATENCY_EN
                    lat_d   = cnt_q;
`endif
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == ISSUE);
        ready_d = (state_d == IDLE);
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            inp_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            to_q    <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MULTI_DRIVER_LATENCY_EN
            lat_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            to_q    <= to_d;
            start_q <= start_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef MULTI_DRIVER_LATENCY_EN
            lat_q   <= lat_d;
`endif
        end
    end

    assign start           = start_q;
    assign inp             = inp_q;
    assign busy            = busy_q;
    assign bus.req_ready   = ready_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_data    = data_q;
    assign bus.rsp_timeout = to_q;
`ifdef MULTI_DRIVER_LATENCY_EN
    assign bus.rsp_latency = lat_q;
`endif

endmodule

// File: doc/multi_driver.md
Name: multi_driver

Overview:
- Initiator-side sequencer for fixed- or variable-latency multi-cycle units that use a start / done / out interface.
- Accepts requests on a valid/ready port, pulses start with the operand, waits for done, captures the unit's result and returns it on a valid/ready response port.
- A timeout guard ensures a unit that never signals done cannot hang the upstream pipeline.
- Sits between the core request fabric and one multi-cycle compute unit.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 4, width of the wait counter.
- TIMEOUT, 8, maximum wait cycles after the start cycle; legal range 1 .. 2^CNT_W-1.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  upstream request valid.
- req_ready  output  1  driver can accept a request.
- req_data  input  WIDTH  request operand.
- start  output  1  one-cycle start pulse to the unit.
- inp  output  WIDTH  operand to the unit; held stable from the start cycle until the response is accepted.
- done  input  1  unit result-valid strobe.
- out  input  WIDTH  unit result, sampled only when done=1.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_data  output  WIDTH  captured result; 0 on timeout.
- rsp_timeout  output  1  qualifies rsp_data; 1 = unit failed to signal done.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, HOLD. All outputs are registered or decoded from state; none depend combinationally on done or out.
- Reset (reset=0, takes effect asynchronously):
  - state=IDLE, start=0, inp=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, wait_cnt=0.
  - req_ready=1 once reset is released.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: inp<=req_data, go to ISSUE.
- ISSUE:
  - Exactly one cycle; start=1, req_ready=0.
  - wait_cnt<=1, go to WAIT.
- WAIT:
  - start=0.
  - If done=1: rsp_data<=out, rsp_timeout<=0, go to HOLD.
  - Else if wait_cnt==TIMEOUT: rsp_data<=0, rsp_timeout<=1, go to HOLD.
  - Else wait_cnt<=wait_cnt+1.
  - done on the same cycle as wait_cnt==TIMEOUT counts as success; done wins.
- HOLD:
  - rsp_valid=1; rsp_data and rsp_timeout stay stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: go to IDLE, rsp_valid<=0.
  - No new request is accepted in HOLD. Minimum request-to-request spacing is 5 cycles with a 2-cycle unit.
- done outside WAIT (IDLE, ISSUE, HOLD) is ignored. It has no effect on state or data.
- Latency, for a unit that raises done 2 cycles after its start cycle:
  - request accepted at edge 0;
  - start high in cycle 1;
  - done in cycle 3 (wait_cnt=2);
  - rsp_valid high in cycle 4.
- wait_cnt never wraps: it saturates at TIMEOUT and is reloaded only in ISSUE.
- Reset asserted mid-operation:
  - any in-flight result is discarded, start drops immediately, and the driver returns to IDLE;
  - a done arriving after reset release is ignored.
- Integration: the unit expects an active-high synchronous reset, supplied by the integrator as !reset.

Optional Feature:
- Macro: MULTI_DRIVER_LATENCY_EN.
- Defined:
  - adds output port rsp_latency [CNT_W-1:0];
  - on WAIT->HOLD it loads wait_cnt (the measured latency, or TIMEOUT on timeout);
  - reset value 0; held stable with rsp_data.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Basic transaction: reset, then req_data=0x0000_00A5; 2-cycle unit returns out=0x0000_00A5 with done in cycle 3 -> start high only in cycle 1; rsp_valid in cycle 4; rsp_data=0xA5; rsp_timeout=0; rsp_latency=2 when the macro is enabled.
- Back-pressure: rsp_ready held 0 for 6 cycles after rsp_valid -> rsp_data and rsp_valid stable throughout, req_ready=0 throughout; IDLE and req_ready=1 the cycle after rsp_ready=1.
- Timeout: TIMEOUT=8, done never asserted -> rsp_valid 9 cycles after start, rsp_data=0, rsp_timeout=1, rsp_latency=8.
- Boundary: done asserted exactly when wait_cnt==TIMEOUT with out=0x1234_5678 -> success; rsp_data=0x1234_5678, rsp_timeout=0.
- Spurious done: done pulsed in IDLE and in HOLD -> no state change, rsp_data unchanged, no extra response.
- Reset mid-WAIT: reset=0 one cycle after start -> start, rsp_valid and busy all 0 immediately; a late done after release is ignored; the next request 0xFFFF_FFFF completes normally.
